spike_encoder: RTL and testbench
================================

// Module: spike_encoder
// PURPOSE
//   Transmit side of the spike link (data/sign pair per channel) that feeds the input neurons of the SNN.
//   Accepts one frame of N_CH signed-magnitude values over a valid/ready handshake.
//   Emits one rate-coded spike train per channel over a fixed window of 2**MAG_W clock cycles.
//   Channel with magnitude m produces exactly m spikes per window, evenly spread by a phase accumulator.
// PARAMETERS
//   N_CH   3   number of output channels (one per input neuron)
//   MAG_W  4   magnitude width; window = 2**MAG_W cycles, max spikes/window = 2**MAG_W-1
// PORTS
//   clk        in   1            system clock, all logic on rising edge
//   rst_n      in   1            asynchronous, active-low reset
//   in_valid   in   1            frame offered
//   in_ready   out  1            encoder can accept a frame this cycle
//   in_mag     in   N_CH*MAG_W   unsigned magnitudes; channel i = in_mag[i*MAG_W +: MAG_W]
//   in_sign    in   N_CH         sign per channel (1 = negative/inhibitory)
//   data_out   out  N_CH         spike per channel, one-cycle pulses
//   sign_out   out  N_CH         sign per channel, high only together with its data_out spike
//   busy       out  1            frame in progress (state RUN)
//   frame_done out  1            one-cycle pulse aligned with last slot of window
// BEHAVIOUR
//   Reset: state IDLE, acc/cnt/latched mag+sign = 0; data_out, sign_out, busy, frame_done = 0. Async assert aborts any frame.
//   in_ready (combinational) = (state==IDLE) | (state==RUN && cnt==2**MAG_W-1). Accept = in_valid & in_ready at an edge.
//   On accept: latch in_mag/in_sign, acc <= ACC_INIT, cnt <= 0, state <= RUN. in_mag/in_sign unsampled at all other times.
//   RUN, each edge (step t = cnt), per channel:
//     {carry, acc_next} = acc + mag (MAG_W+1 bits); acc <= acc_next (wraps mod 2**MAG_W).
//     data_out[i] <= carry; sign_out[i] <= carry & sign[i]; cnt <= cnt+1 (wraps).
//   Step t spike is visible in cycle after edge E(t+1), E0 = accept edge; first slot 2 edges after accept.
//   Last step (cnt==2**MAG_W-1): frame_done <= 1 at same edge; state <= IDLE unless a new accept occurs at that edge.
//     In that case go to RUN with cnt=0 and new data. Windows are back-to-back with no gap slot.
//   IDLE: data_out, sign_out, frame_done <= 0 each edge; busy = 0.
//   busy is registered: 1 from accept edge until the edge ending the last step (unless restarted).
//   Spike count per window: floor((ACC_INIT + 2**MAG_W*m) / 2**MAG_W) = m exactly for any ACC_INIT < 2**MAG_W.
//   Magnitude 0 -> no spikes and sign_out stays 0 regardless of sign. Magnitude max -> 2**MAG_W-1 spikes.
//   in_valid held while not ready: no effect, no loss of in-flight frame.
// CONFIGURATION
//   SPIKE_ENC_CENTER_EN defined: ACC_INIT = 2**(MAG_W-1), which centres sparse trains in the window.
//   SPIKE_ENC_CENTER_EN undefined: ACC_INIT = 0, so sparse trains are late-aligned.
//   Spike count per window is identical in both builds; only slot positions differ.
// STRUCTURE
//   snn_pkg: enc_state_t {ENC_IDLE, ENC_RUN}, link width constants, ACC_INIT function of MAG_W.
//   Sub-module spike_enc_lane (one per channel, generate loop): holds mag/sign/acc.
//     spike_enc_lane ports: clk, rst_n, load, step, mag_in, sign_in, spike, sign.
//   spike_encoder top holds FSM, cnt, handshake, busy, frame_done.
// TESTING (N_CH=3, MAG_W=4, window 16)
//   Reset mid-frame (rst_n low at step 5) -> all outputs 0 asynchronously, in_ready=1 after release, no stale spikes.
//   mag={8,0,15}, sign={0,1,1}, CENTER off -> ch0 spikes at odd steps 1..15 (8 total).
//     Same frame: ch1 has no spikes and sign_out[1]=0; ch2 spikes at steps 1..15 (15 total) with sign_out[2]=1 each.
//   mag ch0=1, CENTER off -> single spike at step 15, coincident with frame_done.
//     Same stimulus, CENTER on -> single spike at step 7.
//   in_valid held high continuously with two frames -> second accepted at step-15 edge.
//     Back-to-back check: step 0 of frame 2 in next cycle, busy stays 1, exactly one frame_done per window.
//   in_valid pulsed mid-frame (in_ready=0) with mag=15 -> ignored, current frame counts unchanged, encoder returns to IDLE.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the spike link encoder.
// Define SPIKE_ENC_CENTER_EN to start the phase accumulator at mid-window.
package snn_pkg;

    localparam int unsigned SNN_N_CH  = 3;
    localparam int unsigned SNN_MAG_W = 4;

`ifdef SPIKE_ENC_CENTER_EN
    localparam bit CENTER_EN = 1'b1;
`else
    localparam bit CENTER_EN = 1'b0;
`endif

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_RUN  = 1'b1
    } enc_state_t;

    // Starting phase: mid-window centres sparse trains, zero late-aligns them
    function automatic int unsigned acc_init(input int unsigned mag_w);
        return CENTER_EN ? (32'd1 << (mag_w - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/spike_enc_lane.sv
// One channel of the rate encoder: latched magnitude/sign and a phase accumulator
// whose carry-out is the spike.
module spike_enc_lane #(
    parameter int unsigned MAG_W    = 4,
    parameter int unsigned ACC_INIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [MAG_W-1:0] mag_in,
    input  logic             sign_in,
    output logic             spike,
    output logic             sign
);

    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] acc;
    logic             sign_q;
    logic [MAG_W:0]   sum_c;

    assign sum_c = {1'b0, acc} + {1'b0, mag};

    // load may coincide with step on a back-to-back restart: spike uses the old frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag    <= '0;
            acc    <= '0;
            sign_q <= 1'b0;
            spike  <= 1'b0;
            sign   <= 1'b0;
        end else begin
            spike <= step & sum_c[MAG_W];
            sign  <= step & sum_c[MAG_W] & sign_q;
            if (load) begin
                mag    <= mag_in;
                sign_q <= sign_in;
                acc    <= MAG_W'(ACC_INIT);
            end else if (step) begin
                acc <= sum_c[MAG_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: accepts a frame of signed magnitudes and emits
// per-channel spike trains over a 2**MAG_W cycle window (see snn_pkg for SPIKE_ENC_CENTER_EN).
module spike_encoder
    import snn_pkg::*;
#(
    parameter int unsigned N_CH  = SNN_N_CH,
    parameter int unsigned MAG_W = SNN_MAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*MAG_W-1:0] in_mag,
    input  logic [N_CH-1:0]       in_sign,
    output logic [N_CH-1:0]       data_out,
    output logic [N_CH-1:0]       sign_out,
    output logic                  busy,
    output logic                  frame_done
);

    enc_state_t       state, state_next;
    logic [MAG_W-1:0] cnt;
    logic             load_c;
    logic             step_c;
    logic             last_c;

    assign last_c = (cnt == {MAG_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake and lane controls; restart on the last step keeps windows gapless
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        in_ready   = 1'b0;
        case (state)
            ENC_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_c     = 1'b1;
                    state_next = ENC_RUN;
                end
            end
            ENC_RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load_c = 1'b1;
                    end else begin
                        state_next = ENC_IDLE;
                    end
                end
            end
            default: state_next = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (load_c) begin
                cnt <= '0;
            end else if (step_c) begin
                cnt <= cnt + MAG_W'(1);
            end
            busy       <= (state_next == ENC_RUN);
            frame_done <= step_c & last_c;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        spike_enc_lane #(
            .MAG_W    (MAG_W),
            .ACC_INIT (acc_init(MAG_W))
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load_c),
            .step    (step_c),
            .mag_in  (in_mag[i*MAG_W +: MAG_W]),
            .sign_in (in_sign[i]),
            .spike   (data_out[i]),
            .sign    (sign_out[i])
        );
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder (N_CH=3, MAG_W=4); expectations follow SPIKE_ENC_CENTER_EN.
module tb_spike_encoder;

    localparam int unsigned N_CH  = 3;
    localparam int unsigned MAG_W = 4;
    localparam int unsigned WIN   = 16;

`ifdef SPIKE_ENC_CENTER_EN
    localparam bit CENTER = 1'b1;
`else
    localparam bit CENTER = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_CH*MAG_W-1:0] in_mag;
    logic [N_CH-1:0]       in_sign;
    logic [N_CH-1:0]       data_out;
    logic [N_CH-1:0]       sign_out;
    logic                  busy;
    logic                  frame_done;

    int n_checks;
    int n_errors;

    logic [WIN-1:0] dm [N_CH];
    logic [WIN-1:0] sm [N_CH];
    logic [WIN-1:0] bm;
    logic [WIN-1:0] fm;

    spike_encoder #(.N_CH(N_CH), .MAG_W(MAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mag     (in_mag),
        .in_sign    (in_sign),
        .data_out   (data_out),
        .sign_out   (sign_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record one 16-step window; optionally pulse a bogus frame at step pulse_at
    task automatic record_window(input int pulse_at);
        for (int c = 0; c < N_CH; c++) begin
            dm[c] = '0;
            sm[c] = '0;
        end
        bm = '0;
        fm = '0;
        for (int t = 0; t < WIN; t++) begin
            if (t == pulse_at) begin
                check("ready_mid_frame", 32'(in_ready), 32'd0);
                in_valid = 1'b1;
                in_mag   = {4'd15, 4'd15, 4'd15};
                in_sign  = 3'b111;
            end
            tick();
            if (t == pulse_at) in_valid = 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                dm[c][t] = data_out[c];
                sm[c][t] = sign_out[c];
            end
            bm[t] = busy;
            fm[t] = frame_done;
        end
    endtask

    task automatic check_frame_8_0_15(input string tag, input logic [WIN-1:0] busy_exp);
        check({tag, "_ch0"},   32'(dm[0]), CENTER ? 32'h5555 : 32'hAAAA);
        check({tag, "_s0"},    32'(sm[0]), 32'h0);
        check({tag, "_ch1"},   32'(dm[1]), 32'h0);
        check({tag, "_s1"},    32'(sm[1]), 32'h0);
        check({tag, "_ch2"},   32'(dm[2]), CENTER ? 32'hFEFF : 32'hFFFE);
        check({tag, "_s2"},    32'(sm[2]), CENTER ? 32'hFEFF : 32'hFFFE);
        check({tag, "_done"},  32'(fm), 32'h8000);
        check({tag, "_busy"},  32'(bm), 32'(busy_exp));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_mag   = '0;
        in_sign  = '0;
        #12;
        check("rst_data",  32'(data_out), 32'd0);
        check("rst_sign",  32'(sign_out), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(in_ready), 32'd1);

        // Basic frame: mag {8,0,15}, sign {0,1,1}
        in_mag   = {4'd15, 4'd0, 4'd8};
        in_sign  = 3'b110;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_mag   = '0;
        in_sign  = '0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_ready", 32'(in_ready), 32'd0);
        record_window(-1);
        check_frame_8_0_15("f1", 16'h7FFF);
        tick();
        check("f1_idle_data", 32'(data_out), 32'd0);
        check("f1_idle_done", 32'(frame_done), 32'd0);
        check("f1_idle_ready", 32'(in_ready), 32'd1);

        // Single spike: mag 1 on ch0
        in_mag   = {4'd0, 4'd0, 4'd1};
        in_sign  = 3'b001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        record_window(-1);
        check("m1_ch0", 32'(dm[0]), CENTER ? 32'h0080 : 32'h8000);
        check("m1_s0",  32'(sm[0]), CENTER ? 32'h0080 : 32'h8000);
        check("m1_ch12", 32'({dm[2], dm[1]}), 32'h0);
        check("m1_done", 32'(fm), 32'h8000);
        tick();

        // Back-to-back: in_valid held across two frames
        in_mag   = {4'd0, 4'd0, 4'd1};
        in_sign  = 3'b000;
        in_valid = 1'b1;
        tick();
        in_mag   = {4'd15, 4'd0, 4'd8};
        in_sign  = 3'b110;
        record_window(-1);
        in_valid = 1'b0;
        check("b2b_a_ch0",  32'(dm[0]), CENTER ? 32'h0080 : 32'h8000);
        check("b2b_a_s0",   32'(sm[0]), 32'h0);
        check("b2b_a_busy", 32'(bm), 32'hFFFF);
        check("b2b_a_done", 32'(fm), 32'h8000);
        record_window(-1);
        check_frame_8_0_15("b2b_b", 16'h7FFF);
        tick();
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Ignored mid-frame offer
        in_mag   = {4'd15, 4'd0, 4'd8};
        in_sign  = 3'b110;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        record_window(4);
        check_frame_8_0_15("ign", 16'h7FFF);
        tick();
        check("ign_idle_busy",  32'(busy), 32'd0);
        check("ign_idle_data",  32'(data_out), 32'd0);
        check("ign_idle_ready", 32'(in_ready), 32'd1);

        // Reset mid-frame at step 5
        in_mag   = {4'd15, 4'd15, 4'd15};
        in_sign  = 3'b111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_data", 32'(data_out), 32'd0);
        check("arst_sign", 32'(sign_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(frame_done), 32'd0);
        #15;
        rst_n = 1'b1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        begin
            logic [N_CH-1:0] seen;
            seen = '0;
            for (int t = 0; t < WIN + 2; t++) begin
                tick();
                seen = seen | data_out | sign_out;
            end
            check("post_rst_stale", 32'(seen), 32'd0);
        end
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
